// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR latch bank controller.
//   state_e : controller FSM states
//   OP_SET / OP_RST : request operation encodings
//   clog2   : ceil(log2(n)), never less than 1, for sizing index fields
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StPulse  = 2'd1,
        StSettle = 2'd2,
        StCheck  = 2'd3
    } state_e;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr, wrapping modulo N.
//   req       : request vector
//   ptr       : highest-priority requester this cycle (caller keeps it < N)
//   en        : when low no grant is issued
//   gnt       : one-hot grant (all zero when nothing granted)
//   gnt_idx   : encoded index of the selected requester (valid whenever any req is set)
//   gnt_valid : a grant is being issued this cycle
module rr_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_valid = en & found;
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// Sequences set/reset pulses onto a bank of external SR latches and checks the result.
// One operation is in flight at a time: grant -> PULSE_CYC cycles of S or R -> SETTLE_CYC idle
// cycles -> one CHECK cycle that samples Q and reports done/err.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/op/idx  : per-requester strobe, op (1=set, 0=reset), packed target index
//   req_grant         : one-hot accept pulse
//   S, R              : latch drive lines, never both high, at most one bit high
//   Q                 : latch outputs (synchronous to clk)
//   done/done_id/err  : completion pulse, owning requester, readback/range error
module sr_latch_bank_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned NLATCH     = 8,
    parameter int unsigned IDXW       = 3,
    parameter int unsigned PULSE_CYC  = 2,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_op,
    input  logic [NREQ*IDXW-1:0]     req_idx,
    output logic [NREQ-1:0]          req_grant,
    output logic [NLATCH-1:0]        S,
    output logic [NLATCH-1:0]        R,
    input  logic [NLATCH-1:0]        Q,
    output logic                     done,
    output logic [clog2(NREQ)-1:0]   done_id,
    output logic                     err
);

    localparam int unsigned IDW     = clog2(NREQ);
    localparam int unsigned CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int unsigned CNTW    = clog2(CNT_MAX);

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            op_q, op_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDW-1:0]  owner_q, owner_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic            arb_valid;
    logic            arb_en;
    logic            idx_ok;
    logic            q_sel;

    // Grants only from IDLE and never while reset is held, so no request is accepted during rst.
    assign arb_en = (state_q == StIdle) & ~rst;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .en        (arb_en),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign req_grant = arb_gnt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        idx_d   = idx_q;
        owner_d = owner_q;
        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StPulse;
                    cnt_d   = CNTW'(PULSE_CYC - 1);
                    ptr_d   = IDW'((32'(arb_idx) + 1) % NREQ);
                    op_d    = req_op[arb_idx];
                    idx_d   = req_idx[arb_idx*IDXW +: IDXW];
                    owner_d = arb_idx;
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    state_d = StSettle;
                    cnt_d   = CNTW'(SETTLE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCheck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            op_q    <= OP_RST;
            idx_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            owner_q <= owner_d;
        end
    end

    assign idx_ok = (32'(idx_q) < NLATCH);

    // Decoding by comparison means an out-of-range index matches no bit: no drive, q_sel = 0.
    always_comb begin
        S     = '0;
        R     = '0;
        q_sel = 1'b0;
        for (int unsigned i = 0; i < NLATCH; i++) begin
            if (idx_q == IDXW'(i)) begin
                q_sel = Q[i];
                if (state_q == StPulse) begin
                    S[i] = (op_q == OP_SET);
                    R[i] = (op_q == OP_RST);
                end
            end
        end
    end

    // A reset arriving during CHECK aborts the op, so done is suppressed in that cycle too.
    assign done    = (state_q == StCheck) & ~rst;
    assign done_id = done ? owner_q : '0;
    assign err     = done & (~idx_ok | (q_sel != op_q));

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Self-checking bench for sr_latch_bank_ctrl: directed vectors, hand sequences for reset and
// out-of-range cases, then random stimulus compared every cycle against a transaction model.
module tb_sr_latch_bank_ctrl;

    localparam int NREQ       = 4;
    localparam int NLATCH     = 8;
    localparam int IDXW       = 3;
    localparam int PULSE_CYC  = 2;
    localparam int SETTLE_CYC = 1;
    localparam int DONE_OFS   = PULSE_CYC + SETTLE_CYC + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid, req_op, req_grant;
    logic [NREQ*IDXW-1:0]   req_idx;
    logic [NLATCH-1:0]      S, R, Q;
    logic                   done, err;
    logic [1:0]             done_id;

    logic [3:0]  v6_valid, v6_op, v6_grant;
    logic [11:0] v6_idx;
    logic [5:0]  s6, r6;
    logic [5:0]  q6 = '0;
    logic        done6, err6;
    logic [1:0]  id6;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    logic [7:0] bank_q = '0;
    logic [7:0] flip   = '0;
    logic [7:0] stuck0 = 8'h80;

    always #5 clk = ~clk;

    sr_latch_bank_ctrl #(
        .NREQ(NREQ), .NLATCH(NLATCH), .IDXW(IDXW), .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
        .req_grant(req_grant), .S(S), .R(R), .Q(Q), .done(done), .done_id(done_id), .err(err)
    );

    sr_latch_bank_ctrl #(
        .NREQ(4), .NLATCH(6), .IDXW(3), .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut6 (
        .clk(clk), .rst(rst), .req_valid(v6_valid), .req_op(v6_op), .req_idx(v6_idx),
        .req_grant(v6_grant), .S(s6), .R(r6), .Q(q6), .done(done6), .done_id(id6), .err(err6)
    );

    // Latch bank model: latch 7 stuck at 0; flip injects readback disturbances.
    always @(posedge clk) begin
        for (int i = 0; i < NLATCH; i++) begin
            if (stuck0[i])  bank_q[i] <= 1'b0;
            else if (S[i])  bank_q[i] <= 1'b1;
            else if (R[i])  bank_q[i] <= 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            if (s6[i])      q6[i] <= 1'b1;
            else if (r6[i]) q6[i] <= 1'b0;
        end
    end
    assign Q = bank_q ^ flip;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic wait_grant(output int who);
        who = -1;
        for (int i = 0; i < 30 && who < 0; i++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) if (req_grant[k]) who = k;
        end
    endtask

    task automatic set_req(input int r, input logic op, input int idx);
        req_op[r]               = op;
        req_idx[r*IDXW +: IDXW] = 3'(idx);
    endtask

    // Transaction-level model: an op granted at cycle g drives its line during g+1..g+PULSE_CYC
    // and completes at g+DONE_OFS; grants only when nothing is in flight.
    initial begin : monitor
        int m_busy, m_t, m_owner, m_idx, m_ptr, sel, c, zero_run;
        logic m_op, e_done, e_err, any, gap_ok, prev_any, seen_pulse;
        logic [3:0] e_gnt;
        logic [7:0] e_s, e_r;
        logic [31:0] e_vec, a_vec;
        m_busy = 0; m_t = 0; m_owner = 0; m_idx = 0; m_ptr = 0; m_op = 1'b0;
        zero_run = 0; prev_any = 1'b0; seen_pulse = 1'b0;
        forever begin
            @(negedge clk);
            sel = -1;
            e_gnt = '0;
            if (!rst && m_busy == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (sel < 0 && req_valid[c]) sel = c;
                end
            end
            if (sel >= 0) e_gnt[sel] = 1'b1;
            e_s = '0;
            e_r = '0;
            if (m_busy != 0 && m_t >= 1 && m_t <= PULSE_CYC && m_idx < NLATCH) begin
                if (m_op) e_s[m_idx] = 1'b1;
                else      e_r[m_idx] = 1'b1;
            end
            e_done = (m_busy != 0) && (m_t == DONE_OFS) && !rst;
            e_err  = (m_idx >= NLATCH) ? 1'b1 : (Q[m_idx] != m_op);
            a_vec = {8'h0, req_grant, S, R, done, e_done ? {done_id, err} : 3'b0};
            e_vec = {8'h0, e_gnt, e_s, e_r, e_done, e_done ? {2'(m_owner), e_err} : 3'b0};
            if (mon_en) check("cycle", a_vec, e_vec);

            any    = |(S | R);
            gap_ok = !(any && !prev_any && seen_pulse && zero_run < SETTLE_CYC + 1);
            if (mon_en) begin
                check("invariant", {31'b0, ((S & R) == 0) && ($countones(S | R) <= 1) && gap_ok},
                      32'd1);
            end
            if (any) begin
                seen_pulse = 1'b1;
                zero_run   = 0;
            end else begin
                zero_run++;
            end
            prev_any = any;
            if (rst) seen_pulse = 1'b0;

            if (rst) begin
                m_busy = 0;
                m_ptr  = 0;
            end else if (m_busy != 0) begin
                if (m_t == DONE_OFS) m_busy = 0;
                else m_t++;
            end else if (sel >= 0) begin
                m_busy  = 1;
                m_t     = 1;
                m_owner = sel;
                m_op    = req_op[sel];
                m_idx   = int'(req_idx[sel*IDXW +: IDXW]);
                m_ptr   = (sel + 1) % NREQ;
            end
        end
    end

    typedef struct {
        int         req;
        logic       op;
        int         idx;
        logic [7:0] exp_s;
        logic [7:0] exp_r;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin : main
        int who;
        vecs[0] = '{req: 0, op: 1'b1, idx: 5, exp_s: 8'h20, exp_r: 8'h00, exp_err: 1'b0};
        vecs[1] = '{req: 1, op: 1'b1, idx: 2, exp_s: 8'h04, exp_r: 8'h00, exp_err: 1'b0};
        vecs[2] = '{req: 1, op: 1'b0, idx: 2, exp_s: 8'h00, exp_r: 8'h04, exp_err: 1'b0};
        vecs[3] = '{req: 3, op: 1'b1, idx: 7, exp_s: 8'h80, exp_r: 8'h00, exp_err: 1'b1};
        vecs[4] = '{req: 2, op: 1'b0, idx: 6, exp_s: 8'h00, exp_r: 8'h40, exp_err: 1'b0};
        vecs[5] = '{req: 2, op: 1'b1, idx: 0, exp_s: 8'h01, exp_r: 8'h00, exp_err: 1'b0};

        rst       = 1'b1;
        req_valid = 4'hf;
        req_op    = '0;
        req_idx   = '0;
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b0, r);
        v6_valid = '0;
        v6_op    = '0;
        v6_idx   = '0;

        // Reset with all requests pending: nothing may leave the controller.
        @(posedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_quiet", {11'b0, req_grant, S, R, done}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_grant", {28'b0, req_grant}, 32'h1);

        // Fairness: all four held valid, grants must rotate 1,2,3,0 after the first.
        for (int n = 1; n < 5; n++) begin
            wait_grant(who);
            check("rr_order", who, n % NREQ);
        end
        @(posedge clk); #1;
        req_valid = '0;

        // Directed single operations, issued back to back.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            set_req(vecs[k].req, vecs[k].op, vecs[k].idx);
            req_valid = 4'(1 << vecs[k].req);
            wait_grant(who);
            check("vec_grant", who, vecs[k].req);
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            check("vec_pulse1", {16'b0, S, R}, {16'b0, vecs[k].exp_s, vecs[k].exp_r});
            @(negedge clk);
            check("vec_pulse2", {16'b0, S, R}, {16'b0, vecs[k].exp_s, vecs[k].exp_r});
            @(negedge clk);
            check("vec_settle", {16'b0, S, R}, 32'd0);
            @(negedge clk);
            check("vec_done", {28'b0, done, done_id, err},
                  {28'b0, 1'b1, 2'(vecs[k].req), vecs[k].exp_err});
        end
        check("latch5_set", {31'b0, bank_q[5]}, 32'd1);
        check("latch2_rst", {31'b0, bank_q[2]}, 32'd0);

        // Reset during the second pulse cycle: pulse dropped, no done, pointer back to 0.
        @(posedge clk); #1;
        set_req(2, 1'b1, 4);
        req_valid = 4'b0100;
        wait_grant(who);
        check("mid_grant", who, 2);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("mid_pulse", {24'b0, S}, 32'h10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 4'hf;
        @(negedge clk);
        check("mid_drop", {16'b0, S, R}, 32'd0);
        check("mid_ptr", {28'b0, req_grant}, 32'h1);
        check("mid_nodone", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_nodone", {31'b0, done}, 32'd0);
        end
        repeat (4) @(negedge clk);

        // Out-of-range index on a 6-latch bank, then an in-range op on the same bank.
        for (int k = 0; k < 2; k++) begin
            int idx6;
            bit got;
            idx6 = (k == 0) ? 7 : 5;
            @(posedge clk); #1;
            v6_op[0]    = 1'b1;
            v6_idx[2:0] = 3'(idx6);
            v6_valid    = 4'b0001;
            got = 1'b0;
            for (int i = 0; i < 30 && !got; i++) begin
                @(negedge clk);
                got = v6_grant[0];
            end
            check("oor_grant", {31'b0, got}, 32'd1);
            @(posedge clk); #1;
            v6_valid = '0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("oor_drive", {20'b0, s6, r6},
                      (k == 1 && i < 2) ? {20'b0, 6'h20, 6'h00} : 32'd0);
            end
            @(negedge clk);
            check("oor_done", {30'b0, done6, err6}, (k == 0) ? 32'd3 : 32'd2);
        end

        // Random traffic with occasional readback flips and resets; the monitor checks it all.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            req_valid = 4'($urandom_range(0, 15));
            req_op    = 4'($urandom);
            req_idx   = 12'($urandom);
            flip      = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            rst       = ($urandom_range(0, 79) == 0);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        flip      = '0;
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
